// File: rtl/button_counter_param.sv
// button_counter_param: up/down counter driven by two asynchronous push buttons.
// Each button is synchronized, debounced and edge-detected. Every accepted press
// steps the count by STEP, which either saturates or wraps at 0 / MAX_VAL.
// All outputs are registered.
module button_counter_param #(
  parameter int WIDTH    = 16,
  parameter int MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int STEP     = 1,
  parameter int DEBOUNCE = 2,
  parameter int WRAP     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  output logic [WIDTH-1:0] c_out,
  output logic             at_min,
  output logic             at_max,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             lim_hit
);

  // The debounce counter only has to reach DEBOUNCE-1; the level flips on the
  // edge that would have made it DEBOUNCE.
  localparam int             CW        = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [CW-1:0]  DB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  DB_ONE    = CW'(1);
  localparam logic [CW-1:0]  DB_ZERO   = CW'(0);

  // Count arithmetic is carried in WIDTH+1 bits, so MAX_VAL+1 and c_out+STEP
  // are represented exactly before they are compared against the limits.
  localparam logic [WIDTH:0] MAX_X     = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] MODULUS_X = MAX_X + (WIDTH + 1)'(1);
  localparam logic [WIDTH:0] ZERO_X    = (WIDTH + 1)'(0);
  localparam logic           WRAP_EN   = (WRAP != 0);

  // Bit 0 carries the up button and bit 1 carries the down button.
  logic [1:0]         sync1_q;
  logic [1:0]         sync2_q;
  logic [1:0]         level_q;
  logic [1:0]         level_d;
  logic [1:0]         press_q;
  logic [1:0]         press_d;
  logic [1:0][CW-1:0] db_cnt_q;
  logic [1:0][CW-1:0] db_cnt_d;

  logic [WIDTH-1:0]   c_out_q;
  logic               at_min_q;
  logic               at_max_q;
  logic               up_pulse_q;
  logic               dn_pulse_q;
  logic               lim_hit_q;

  logic [WIDTH:0]     cnt_x;
  logic [WIDTH:0]     up_sum;
  logic [WIDTH:0]     up_wrap;
  logic [WIDTH:0]     dn_sub;
  logic [WIDTH:0]     dn_wrap;
  logic [WIDTH:0]     nxt_x;
  logic               up_pulse_d;
  logic               dn_pulse_d;
  logic               lim_hit_d;

  // Debounce: the level follows the synchronized input only after DEBOUNCE
  // consecutive mismatching edges. Any agreeing edge restarts the count.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    press_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = DB_ZERO;
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end else begin
        db_cnt_d[i] = DB_ZERO;
      end
    end
  end

  // Two-flop synchronizers, debounce state and registered press strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      level_q  <= 2'b00;
      db_cnt_q <= '{DB_ZERO, DB_ZERO};
      press_q  <= 2'b00;
    end else begin
      sync1_q  <= {d, u};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // Next count value. Simultaneous up and down presses cancel each other.
  always_comb begin
    cnt_x      = {1'b0, c_out_q};
    up_sum     = cnt_x + STEP_X;
    up_wrap    = up_sum - MODULUS_X;
    dn_sub     = cnt_x - STEP_X;
    dn_wrap    = cnt_x + MODULUS_X - STEP_X;
    nxt_x      = cnt_x;
    up_pulse_d = 1'b0;
    dn_pulse_d = 1'b0;
    lim_hit_d  = 1'b0;
    case (press_q)
      2'b01: begin
        up_pulse_d = 1'b1;
        if (up_sum <= MAX_X) begin
          nxt_x = up_sum;
        end else begin
          lim_hit_d = 1'b1;
          if (WRAP_EN) begin
            nxt_x = up_wrap;
          end else begin
            nxt_x = MAX_X;
          end
        end
      end
      2'b10: begin
        dn_pulse_d = 1'b1;
        if (cnt_x >= STEP_X) begin
          nxt_x = dn_sub;
        end else begin
          lim_hit_d = 1'b1;
          if (WRAP_EN) begin
            nxt_x = dn_wrap;
          end else begin
            nxt_x = ZERO_X;
          end
        end
      end
      default: begin
        nxt_x = cnt_x;
      end
    endcase
  end

  // Count, limit flags and one-cycle pulses, all updated together.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_out_q    <= {WIDTH{1'b0}};
      at_min_q   <= 1'b1;
      at_max_q   <= 1'b0;
      up_pulse_q <= 1'b0;
      dn_pulse_q <= 1'b0;
      lim_hit_q  <= 1'b0;
    end else begin
      c_out_q    <= nxt_x[WIDTH-1:0];
      at_min_q   <= (nxt_x == ZERO_X);
      at_max_q   <= (nxt_x == MAX_X);
      up_pulse_q <= up_pulse_d;
      dn_pulse_q <= dn_pulse_d;
      lim_hit_q  <= lim_hit_d;
    end
  end

  assign c_out    = c_out_q;
  assign at_min   = at_min_q;
  assign at_max   = at_max_q;
  assign up_pulse = up_pulse_q;
  assign dn_pulse = dn_pulse_q;
  assign lim_hit  = lim_hit_q;

endmodule

// File: tb/tb_button_counter_param.sv
// Bench for button_counter_param: two instances (default parameters and a
// WIDTH=4 / MAX_VAL=9 / STEP=3 / WRAP=1 configuration) share one stimulus.
// A press-level reference model queues the expected pulse cycles, and a monitor
// compares the DUT outputs against those expectations.
module tb_button_counter_param;

  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        u;
  logic        d;

  logic [15:0] c0;
  logic        amin0, amax0, up0, dn0, lim0;
  logic [3:0]  c1;
  logic        amin1, amax1, up1, dn1, lim1;

  button_counter_param dut0 (
    .clk(clk), .reset(reset), .u(u), .d(d),
    .c_out(c0), .at_min(amin0), .at_max(amax0),
    .up_pulse(up0), .dn_pulse(dn0), .lim_hit(lim0)
  );

  button_counter_param #(
    .WIDTH(4), .MAX_VAL(9), .STEP(3), .DEBOUNCE(DEB), .WRAP(1)
  ) dut1 (
    .clk(clk), .reset(reset), .u(u), .d(d),
    .c_out(c1), .at_min(amin1), .at_max(amax1),
    .up_pulse(up1), .dn_pulse(dn1), .lim_hit(lim1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit up;
    bit dn;
    bit lim;
  } exp_t;

  exp_t exp_q[2][$];
  int   mdl_cnt[2];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Press-detection state of the reference model, with one entry per button (0 = up, 1 = down).
  bit   dly1[2];
  bit   dly2[2];
  bit   run_val[2];
  int   run_len[2];
  bit   level[2];
  bit   pend[2];

  function automatic int cfg_max(input int c);
    return (c == 0) ? 65535 : 9;
  endfunction

  function automatic int cfg_step(input int c);
    return (c == 0) ? 1 : 3;
  endfunction

  function automatic bit cfg_wrap(input int c);
    return (c == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Applies one press decision to the count of configuration c and queues the expected pulse cycle.
  task automatic apply(input int c, input bit pu, input bit pd);
    exp_t e;
    int   mx;
    int   st;
    int   nv;
    bit   lim;
    mx  = cfg_max(c);
    st  = cfg_step(c);
    nv  = mdl_cnt[c];
    lim = 1'b0;
    if (pu != pd) begin
      if (pu) begin
        if (nv + st <= mx) nv = nv + st;
        else begin
          lim = 1'b1;
          nv  = cfg_wrap(c) ? (nv + st - (mx + 1)) : mx;
        end
      end else begin
        if (nv >= st) nv = nv - st;
        else begin
          lim = 1'b1;
          nv  = cfg_wrap(c) ? (nv + (mx + 1) - st) : 0;
        end
      end
      mdl_cnt[c] = nv;
      e.cnt = nv;
      e.up  = pu;
      e.dn  = pd;
      e.lim = lim;
      exp_q[c].push_back(e);
    end
  endtask

  // One clock edge of the reference model. A button's level changes once its
  // input has shown the new value for DEB samples; the sample reaches the debouncer two edges late.
  // A new high level is a press, and the count reacts one edge later.
  task automatic model_step();
    bit x;
    bit np[2];
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        dly1[b] = 1'b0; dly2[b] = 1'b0; run_val[b] = 1'b0;
        run_len[b] = 0; level[b] = 1'b0; pend[b] = 1'b0;
      end
      mdl_cnt[0] = 0;
      mdl_cnt[1] = 0;
    end else begin
      apply(0, pend[0], pend[1]);
      apply(1, pend[0], pend[1]);
      for (int b = 0; b < 2; b++) begin
        x = dly2[b];
        dly2[b] = dly1[b];
        dly1[b] = (b == 0) ? u : d;
        if (x == run_val[b]) run_len[b]++;
        else begin
          run_val[b] = x;
          run_len[b] = 1;
        end
        np[b] = 1'b0;
        if (run_len[b] >= DEB && x != level[b]) begin
          level[b] = x;
          np[b]    = x;
        end
      end
      pend[0] = np[0];
      pend[1] = np[1];
    end
  endtask

  // Compares one configuration against the model and, on a pulse cycle, against the next queued entry.
  task automatic check_cfg(input int c, input int cv, input bit amin, input bit amax,
                           input bit up, input bit dn, input bit lim);
    exp_t e;
    chk($sformatf("cfg%0d c_out", c), cv, mdl_cnt[c]);
    chk($sformatf("cfg%0d at_min", c), int'(amin), int'(mdl_cnt[c] == 0));
    chk($sformatf("cfg%0d at_max", c), int'(amax), int'(mdl_cnt[c] == cfg_max(c)));
    if (up || dn || lim || exp_q[c].size() != 0) begin
      if (exp_q[c].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cfg%0d unexpected_pulse actual up=%0d dn=%0d lim=%0d expected no pulse at %0t",
                 c, up, dn, lim, $time);
      end else begin
        e = exp_q[c].pop_front();
        chk($sformatf("cfg%0d up_pulse", c), int'(up), int'(e.up));
        chk($sformatf("cfg%0d dn_pulse", c), int'(dn), int'(e.dn));
        chk($sformatf("cfg%0d lim_hit", c), int'(lim), int'(e.lim));
        chk($sformatf("cfg%0d pulse c_out", c), cv, e.cnt);
      end
    end
  endtask

  // Reference model, advanced on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor, which samples both DUTs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_cfg(0, int'(c0), amin0, amax0, up0, dn0, lim0);
        check_cfg(1, int'(c1), amin1, amax1, up1, dn1, lim1);
      end
    end
  end

  task automatic drive(input bit uu, input bit dd, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u = uu;
      d = dd;
    end
  endtask

  task automatic rst_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press(input int b);
    drive(b == 0, b == 1, DEB + 1);
    drive(1'b0, 1'b0, 5);
  endtask

  initial begin
    reset = 1'b1;
    u     = 1'b0;
    d     = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic up, up, down sequence.
    press(0);
    press(0);
    press(1);
    chk("dir cfg0 after u,u,d", int'(c0), 1);
    chk("dir cfg1 after u,u,d", int'(c1), 3);

    // A one-cycle glitch is ignored.
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 6);
    chk("dir cfg0 after glitch", int'(c0), 1);

    // Down to zero, then down at zero (saturate or wrap).
    press(1);
    press(1);
    chk("dir cfg0 down at zero", int'(c0), 0);
    chk("dir cfg1 down wrap", int'(c1), 7);

    // Both buttons together cancel.
    drive(1'b1, 1'b1, 3);
    drive(1'b0, 1'b0, 6);
    chk("dir cfg1 after cancel", int'(c1), 7);

    // Wrap configuration: 3, 6, 9, 2 and then down to 9.
    rst_hold(2);
    press(0); press(0); press(0); press(0);
    chk("dir cfg1 up wrap", int'(c1), 2);
    press(1);
    chk("dir cfg0 after 4u,1d", int'(c0), 3);
    chk("dir cfg1 down wrap from 2", int'(c1), 9);

    // A down press while up is held still counts.
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 3);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 6);
    chk("dir cfg0 down while up held", int'(c0), 3);
    chk("dir cfg1 down while up held", int'(c1), 9);

    // A button held through reset counts once afterwards.
    drive(1'b1, 1'b0, 2);
    rst_hold(2);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 6);
    chk("dir cfg0 press held through reset", int'(c0), 1);

    // Randomized segments, with occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 99) < 3) rst_hold(int'($urandom_range(1, 2)));
      else drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(1, 5)));
    end

    drive(1'b0, 1'b0, 10);
    chk("cfg0 expected queue drained", exp_q[0].size(), 0);
    chk("cfg1 expected queue drained", exp_q[1].size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
